t_slot_loader_13: RTL and testbench
===================================

# t_slot_loader_13

Writer-side counterpart of the 13-slot byte selector: accepts a framed byte stream over a valid/ready handshake, fills 13 staging slots in order, and commits all 13 to output registers atomically when a frame completes. Its outputs drive the 13 data inputs `x0`..`x12` of the slot selector, so the selector never sees a half-written frame.

## Interface
- `RESET_BYTE`, default 8'h20: reset and power-up value of every staging and output slot.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  byte present on `wr_data`.
- `wr_sof`  in  1  start of frame; qualified by `wr_valid`, marks the slot-0 byte.
- `wr_data`  in  8  byte to store.
- `wr_ready`  out  1  loader can accept a byte; transfer occurs when `wr_valid & wr_ready` at a rising edge.
- `x0`..`x12`  out  8 each  committed slot values; registered.
- `frame_done`  out  1  one-cycle pulse; high in the first cycle the new committed values are visible.
- `drop_err`  out  1  one-cycle registered pulse; a byte was accepted and discarded.
- `wr_idx`  out  4  next staging slot to be written, 0..12.

## Operation
- States: IDLE, LOAD, COMMIT. Reset enters IDLE.
- IDLE: `wr_ready`=1.
  - Accepted byte with `wr_sof`=1: write staging[0], `wr_idx`<=1, go to LOAD.
  - Accepted byte with `wr_sof`=0: discard, pulse `drop_err`, stay in IDLE.
- LOAD: `wr_ready`=1.
  - Accepted byte with `wr_sof`=0: write staging[`wr_idx`], then increment `wr_idx`.
  - Accepted byte with `wr_sof`=1: restart. Write staging[0], set `wr_idx`<=1. The partial frame is abandoned and not committed; no `drop_err`.
  - Write to slot 12: go to COMMIT with `wr_idx`<=0.
- COMMIT: `wr_ready`=0 for exactly one cycle. At the next edge, all 13 outputs load from staging in the same edge, `frame_done` is set high for one cycle, and the state returns to IDLE.
- Single-byte frame: not possible. A frame is exactly 13 accepted bytes, the first carrying `wr_sof`.
- Staging slots not rewritten in a restarted frame keep their old values. They are always overwritten before the next commit, because a commit requires writes to slots 0..12 in order.
- Committed outputs change only at a COMMIT edge or on reset. They are never affected by LOAD activity.
- `wr_idx` never exceeds 12; there is no wrap past 12 without a commit.

## Timing
- Reset values: all `x*` = `RESET_BYTE`, staging = `RESET_BYTE`, `wr_idx`=0, `frame_done`=0, `drop_err`=0, `wr_ready`=1 (IDLE).
- Throughput: one byte per cycle in IDLE and LOAD. A full frame takes 13 transfer cycles plus 1 COMMIT cycle, so at most 1 frame per 14 cycles.
- Latency: 13th byte accepted at edge N. Cycle N→N+1 is in COMMIT with `wr_ready`=0. At edge N+1, `x*` update and `frame_done`=1 during cycle N+1→N+2.
- `wr_ready` is a combinational decode of the state register only; it never depends on `wr_valid`.
- `wr_valid` held high while `wr_ready`=0: no transfer; the byte must be held by the source and is accepted in IDLE on the next cycle. If that byte lacks `wr_sof`, it is dropped with `drop_err`.
- Reset during LOAD or COMMIT:
  - Returns to IDLE next edge, restores all reset values, and suppresses `frame_done`.
  - A commit pending in the same cycle does not occur.
- Reset has priority over any simultaneous transfer.
- `drop_err` and `frame_done` are never high in the same cycle.

## Test plan
- Reset check: after `reset`, all `x0`..`x12`=8'h20, `wr_ready`=1, `wr_idx`=0, no pulses.
- Back-to-back frame: stream bytes 8'h41..8'h4D, the first with sof, one per cycle. Outputs hold 8'h20 through the 13th accept. `wr_ready`=0 for one cycle, then `x0`=8'h41 … `x12`=8'h4D with `frame_done` high for exactly that cycle.
- Restart mid-frame: send 5 bytes 8'h30..8'h34, then sof with 8'h61 followed by 12 bytes 8'h62..8'h6D.
  - No commit after the first 5.
  - Final `x0`=8'h61, `x12`=8'h6D.
  - Exactly one `frame_done`.
- Orphan bytes: in IDLE send 3 bytes with sof=0. Expect 3 `drop_err` pulses, `wr_idx` stays 0, outputs unchanged. Then a valid frame commits normally.
- Backpressure at commit: hold `wr_valid`=1 with a sof byte 8'h55 during the COMMIT cycle. It is not accepted in COMMIT. It is accepted the next cycle as slot 0 of the new frame (`wr_idx`=1), and the previous frame's committed outputs are intact.
- Reset mid-frame: reset asserted after 12 bytes, then the 13th byte is presented. Expect no `frame_done`, outputs = 8'h20, and the 13th byte without sof produces `drop_err`.

Source files
------------

// File: rtl/t_slot_loader_13.sv
// Writer side of the 13-slot byte selector: collects a framed byte stream into
// staging slots and commits all 13 to the registered outputs atomically.
module t_slot_loader_13 #(
  parameter logic [7:0] RESET_BYTE = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic       wr_sof,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [7:0] x0,
  output logic [7:0] x1,
  output logic [7:0] x2,
  output logic [7:0] x3,
  output logic [7:0] x4,
  output logic [7:0] x5,
  output logic [7:0] x6,
  output logic [7:0] x7,
  output logic [7:0] x8,
  output logic [7:0] x9,
  output logic [7:0] x10,
  output logic [7:0] x11,
  output logic [7:0] x12,
  output logic       frame_done,
  output logic       drop_err,
  output logic [3:0] wr_idx
);

  localparam int unsigned NUM_SLOTS = 13;
  localparam logic [3:0]  LAST_SLOT = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_stage [NUM_SLOTS];
  logic [7:0] r_out   [NUM_SLOTS];
  logic [3:0] r_idx;
  logic [3:0] w_idx_next;
  logic [3:0] w_wr_slot;
  logic       w_wr_en;
  logic       w_drop;
  logic       w_commit;
  logic       w_accept;
  logic       r_frame_done;
  logic       r_drop_err;

  // Ready depends on the state register alone, never on wr_valid.
  assign wr_ready = (r_state != ST_COMMIT);
  assign w_accept = wr_valid & wr_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_wr_en      = 1'b0;
    w_wr_slot    = 4'd0;
    w_drop       = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (wr_sof) begin
            w_wr_en      = 1'b1;
            w_idx_next   = 4'd1;
            w_state_next = ST_LOAD;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (wr_sof) begin
            // Restart: the partial frame is abandoned without an error pulse.
            w_idx_next = 4'd1;
          end else begin
            w_wr_slot = r_idx;
            if (r_idx == LAST_SLOT) begin
              w_idx_next   = 4'd0;
              w_state_next = ST_COMMIT;
            end else begin
              w_idx_next = r_idx + 4'd1;
            end
          end
        end
      end
      ST_COMMIT: begin
        w_commit     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the slot arrays are reset on purpose; their reset value is
      // architecturally visible on the outputs and in any commit.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_stage[i] <= RESET_BYTE;
        r_out[i]   <= RESET_BYTE;
      end
      r_idx        <= 4'd0;
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      if (w_wr_en) r_stage[w_wr_slot] <= wr_data;
      if (w_commit) begin
        for (int i = 0; i < NUM_SLOTS; i++) r_out[i] <= r_stage[i];
      end
      r_idx        <= w_idx_next;
      r_frame_done <= w_commit;
      r_drop_err   <= w_drop;
    end
  end

  assign x0         = r_out[0];
  assign x1         = r_out[1];
  assign x2         = r_out[2];
  assign x3         = r_out[3];
  assign x4         = r_out[4];
  assign x5         = r_out[5];
  assign x6         = r_out[6];
  assign x7         = r_out[7];
  assign x8         = r_out[8];
  assign x9         = r_out[9];
  assign x10        = r_out[10];
  assign x11        = r_out[11];
  assign x12        = r_out[12];
  assign frame_done = r_frame_done;
  assign drop_err   = r_drop_err;
  assign wr_idx     = r_idx;

endmodule

// File: tb/tb_t_slot_loader_13.sv
// Self-checking bench for t_slot_loader_13: directed frame scenarios followed by
// random traffic, all compared against a queue-based frame model.
module tb_t_slot_loader_13;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_sof;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12;
  logic       frame_done;
  logic       drop_err;
  logic [3:0] wr_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bytes of the frame in progress, last committed frame, pending commit.
  logic [7:0] m_frame [$];
  logic [7:0] m_out [13];
  bit         m_pending;
  bit         m_fd;
  bit         m_drop;

  always #5 clk = ~clk;

  t_slot_loader_13 #(.RESET_BYTE(8'h20)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_sof(wr_sof),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6),
    .x7(x7), .x8(x8), .x9(x9), .x10(x10), .x11(x11), .x12(x12),
    .frame_done(frame_done), .drop_err(drop_err), .wr_idx(wr_idx)
  );

  task automatic check(input string tag, input logic [103:0] got, input logic [103:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [103:0] model_outs();
    logic [103:0] r;
    for (int i = 0; i < 13; i++) r[i*8 +: 8] = m_out[i];
    return r;
  endfunction

  function automatic logic [103:0] dut_outs();
    return {x12, x11, x10, x9, x8, x7, x6, x5, x4, x3, x2, x1, x0};
  endfunction

  task automatic model_reset();
    m_frame.delete();
    for (int i = 0; i < 13; i++) m_out[i] = 8'h20;
    m_pending = 1'b0;
    m_fd      = 1'b0;
    m_drop    = 1'b0;
  endtask

  // One clock: drive inputs, check ready, advance model at the edge, check outputs.
  task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] d);
    bit acc;
    reset    = rst;
    wr_valid = v;
    wr_sof   = s;
    wr_data  = d;
    #1;
    check("wr_ready", wr_ready, !m_pending);
    acc = v && !m_pending;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_fd   = 1'b0;
      m_drop = 1'b0;
      if (m_pending) begin
        for (int i = 0; i < 13; i++) m_out[i] = m_frame[i];
        m_frame.delete();
        m_pending = 1'b0;
        m_fd      = 1'b1;
      end else if (acc) begin
        if (s) begin
          m_frame.delete();
          m_frame.push_back(d);
        end else if (m_frame.size() == 0) begin
          m_drop = 1'b1;
        end else begin
          m_frame.push_back(d);
          if (m_frame.size() == 13) m_pending = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("outputs", dut_outs(), model_outs());
    check("frame_done", frame_done, m_fd);
    check("drop_err", drop_err, m_drop);
    check("wr_idx", wr_idx, m_pending ? 4'd0 : 4'(m_frame.size()));
  endtask

  task automatic send_bytes(input logic [7:0] first, input int n, input bit sof_first);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, sof_first && (i == 0), first + 8'(i));
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    wr_data  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_x0", x0, 8'h20);
    check("rst_x12", x12, 8'h20);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Back-to-back frame 41..4D, commit cycle, then one visible cycle
    send_bytes(8'h41, 13, 1'b1);
    check("bb_hold_x0", x0, 8'h20);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("bb_x0", x0, 8'h41);
    check("bb_x12", x12, 8'h4D);
    check("bb_done", frame_done, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("bb_done_clr", frame_done, 1'b0);

    // Restart mid-frame
    send_bytes(8'h30, 5, 1'b1);
    send_bytes(8'h61, 13, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("rs_x0", x0, 8'h61);
    check("rs_x12", x12, 8'h6D);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Orphan bytes in IDLE, then a normal frame
    send_bytes(8'h90, 3, 1'b0);
    check("orph_idx", wr_idx, 4'd0);
    send_bytes(8'hA0, 13, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("orph_frame_x5", x5, 8'hA5);

    // Backpressure at commit: sof byte held across the COMMIT cycle
    send_bytes(8'hB0, 13, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    check("bp_x3", x3, 8'hB3);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    check("bp_idx", wr_idx, 4'd1);
    check("bp_x12", x12, 8'hBC);

    // Reset mid-frame, 13th byte presented during and after reset
    step(1'b0, 1'b0, 1'b0, 8'h00);
    send_bytes(8'hC0, 12, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hCC);
    step(1'b0, 1'b1, 1'b0, 8'hCC);
    check("rm_drop", drop_err, 1'b1);
    check("rm_x0", x0, 8'h20);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
